// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalized 29-bit fraction, renormalizes on a
// rounding carry and packs an IEEE-754 single-precision word with flags.
// Optional feature macro: ROUND_NEAREST_EVEN_EN (defined = round to nearest
// even, RENORM reachable; undefined = truncation, fixed three-edge latency).
module fp_round_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [28:0] fract_in,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned EXPX_W  = EXP_W + 1;
  localparam int unsigned FRACT_W = 29;
  localparam int unsigned MANT_W  = 24;
  localparam int unsigned SUM_W   = MANT_W + 1;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROUND  = 3'd1,
    S_RENORM = 3'd2,
    S_PACK   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [EXPX_W-1:0]    exp_q, exp_d;
  logic [FRACT_W-1:0]   fract_q, fract_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [WORD_W-1:0]    result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 inexact_q, inexact_d;

  logic [MANT_W-1:0]    mant_c;
  logic                 round_inc_c;
  logic [SUM_W-1:0]     sum_c;
  logic                 grs_any_c;

  // Rounding increment and 25-bit rounded sum from the latched fraction
  always_comb begin
    mant_c = fract_q[26:3];
`ifdef ROUND_NEAREST_EVEN_EN
    round_inc_c = fract_q[2] & (fract_q[1] | fract_q[0] | mant_c[0]);
`else
    round_inc_c = 1'b0;
`endif
    sum_c     = {1'b0, mant_c} + SUM_W'(round_inc_c);
    grs_any_c = |fract_q[2:0];
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    fract_d     = fract_q;
    sum_d       = sum_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          exp_d   = {1'b0, exp_in};
          fract_d = fract_in;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        sum_d   = sum_c;
        state_d = sum_c[SUM_W-1] ? S_RENORM : S_PACK;
      end

      // Rounding carried out of the mantissa: shift right, bump exponent
      S_RENORM: begin
        sum_d   = {1'b0, sum_q[SUM_W-1:1]};
        exp_d   = exp_q + EXPX_W'(1);
        state_d = S_PACK;
      end

      S_PACK: begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (fract_q == '0) begin
          result_d  = {sign_q, 31'b0};
          inexact_d = 1'b0;
        end else if (exp_q == '0) begin
          result_d    = {sign_q, 31'b0};
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end else if (exp_q >= EXPX_W'(255)) begin
          result_d   = {sign_q, 8'hFF, 23'b0};
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end else begin
          result_d  = {sign_q, exp_q[EXP_W-1:0], sum_q[FRAC_W-1:0]};
          inexact_d = grs_any_c;
        end
        state_d = S_DONE;
      end

      // Hold the packed word; a new start clears it and relatches inputs
      S_DONE: begin
        if (start) begin
          sign_d      = sign_in;
          exp_d       = {1'b0, exp_in};
          fract_d     = fract_in;
          result_d    = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
          state_d     = S_ROUND;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ROUND) || (state_d == S_RENORM) || (state_d == S_PACK);
    // done rises one edge after DONE is entered and drops on an accepted start
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      fract_q     <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      fract_q     <= fract_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboarded random/directed bench for fp_round_pack. Expected words come
// from an integer rounding model; a monitor checks each done pulse.
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = 8'd0;
  logic [28:0] fract_in = 29'd0;
  logic [31:0] result;
  logic        busy, done, overflow, underflow, inexact;

  fp_round_pack dut (
    .clk(clk), .reset(reset), .start(start), .sign_in(sign_in),
    .exp_in(exp_in), .fract_in(fract_in), .result(result), .busy(busy),
    .done(done), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    logic        ix;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: integer mantissa, round on the 3-bit remainder, then pack
  function automatic exp_t model(input bit s, input bit [7:0] e, input bit [28:0] f);
    exp_t     r;
    longint   m;
    int       ee;
    int       grs;
    bit [7:0] eb;
    bit [22:0] mb;
    m = longint'(f[26:3]);
    grs = int'(f[2:0]);
    ee = int'(e);
    r.lat = 3;
    r.t0 = 0;
`ifdef ROUND_NEAREST_EVEN_EN
    if (grs > 4 || (grs == 4 && (m % 2) == 1)) m = m + 1;
    if (m >= 64'd16777216) begin
      m = m / 2;
      ee = ee + 1;
      r.lat = 4;
    end
`endif
    r.ov = 1'b0;
    r.uf = 1'b0;
    r.ix = (grs != 0);
    if (f == 29'd0) begin
      r.res = {s, 31'b0};
      r.ix = 1'b0;
    end else if (ee == 0) begin
      r.res = {s, 31'b0};
      r.uf = 1'b1;
      r.ix = 1'b1;
    end else if (ee >= 255) begin
      r.res = {s, 8'hFF, 23'b0};
      r.ov = 1'b1;
      r.ix = 1'b1;
    end else begin
      eb = 8'(ee);
      mb = 23'(m);
      r.res = {s, eb, mb};
    end
    return r;
  endfunction

  // Monitor: each rising done pops and checks one expected response
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", {29'd0, overflow, underflow, inexact}, {29'd0, e.ov, e.uf, e.ix});
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    done_prev = done;
  end

  // Issue one operation; hold=1 keeps start high while busy with altered inputs
  task automatic issue(input bit s, input bit [7:0] e, input bit [28:0] f, input bit hold);
    exp_t x;
    bit   seen;
    @(negedge clk);
    sign_in = s;
    exp_in = e;
    fract_in = f;
    start = 1'b1;
    x = model(s, e, f);
    x.t0 = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("result_cleared", result, 32'd0);
    chk("flags_cleared", {29'd0, overflow, underflow, inexact}, 32'd0);
    if (hold) begin
      sign_in = ~s;
      exp_in = e ^ 8'h5A;
      fract_in = f ^ 29'h0155_5555;
    end else begin
      start = 1'b0;
      sign_in = 1'($urandom);
      exp_in = 8'($urandom);
      fract_in = 29'($urandom);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got done=0, expected done=1 within 10 cycles");
      sb.delete();
    end else begin
      @(negedge clk);
      chk("result_held", result, x.res);
    end
  endtask

  task automatic directed(input string name, input bit s, input bit [7:0] e,
                          input bit [28:0] f, input logic [31:0] want);
    issue(s, e, f, 1'b0);
    chk(name, result, want);
  endtask

  initial begin
    bit [7:0]  re;
    bit [28:0] rf;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {result[27:0], busy, done, overflow, underflow},
        32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_inexact", {31'd0, inexact}, 32'd0);
    reset = 1'b1;

    directed("one", 1'b0, 8'd127, 29'h0400_0000, 32'h3F80_0000);
`ifdef ROUND_NEAREST_EVEN_EN
    directed("round_carry", 1'b0, 8'd127, 29'h07FF_FFFF, 32'h4000_0000);
    directed("tie_odd", 1'b0, 8'd127, 29'h0400_000C, 32'h3F80_0002);
    directed("overflow", 1'b1, 8'd254, 29'h07FF_FFFF, 32'hFF80_0000);
`else
    directed("round_carry", 1'b0, 8'd127, 29'h07FF_FFFF, 32'h3FFF_FFFF);
    directed("tie_odd", 1'b0, 8'd127, 29'h0400_000C, 32'h3F80_0001);
    directed("overflow", 1'b1, 8'd254, 29'h07FF_FFFF, 32'hFF7F_FFFF);
`endif
    directed("tie_even", 1'b0, 8'd127, 29'h0400_0004, 32'h3F80_0000);
    directed("neg_zero", 1'b1, 8'd100, 29'h0000_0000, 32'h8000_0000);
    directed("underflow", 1'b0, 8'd0, 29'h0400_0000, 32'h0000_0000);
    directed("exp255", 1'b0, 8'd255, 29'h0400_0000, 32'h7F80_0000);

    // start held high through the busy window must not relatch
    issue(1'b0, 8'd130, 29'h0523_4567, 1'b1);

    // Asynchronous reset in ROUND aborts the operation
    @(negedge clk);
    sign_in = 1'b1;
    exp_in = 8'd127;
    fract_in = 29'h07FF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_outputs", {result[27:0], busy, done, overflow, underflow}, 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    directed("after_abort", 1'b0, 8'd127, 29'h0400_0000, 32'h3F80_0000);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: re = 8'd0;
        1: re = 8'd254;
        2: re = 8'd255;
        3: re = 8'd1;
        default: re = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rf = 29'd0;
        1: rf = {2'b00, 1'b1, 23'h7F_FFFF, 3'($urandom)};
        default: rf = {2'b00, 1'b1, 26'($urandom)};
      endcase
      issue(1'($urandom), re, rf, ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
